mem_port_sequencer: RTL and testbench

//  Shares one unified, variable-latency memory port between the MIPS core's instruction fetch and data access.
//  - Sequences every instruction as FETCH -> optional DATA -> COMMIT.
//  - Holds the core stalled until the instruction and any load/store data are available.
//  - Sits between MIPScore (imem/dmem sides) and the external memory.

---
 rtl/mem_port_sequencer_pkg.sv | 16 +
 rtl/mem_port_sequencer_ack_timeout.sv | 37 +++
 rtl/mem_port_sequencer.sv | 142 ++++++++++++++
 tb/tb_mem_port_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_sequencer_pkg.sv
// Shared types and defaults for the unified memory port sequencer.
// Holds state encodings and default widths.
package mem_port_sequencer_pkg;

  localparam int AW_DEF  = 32;
  localparam int DW_DEF  = 32;
  localparam int TMO_DEF = 255;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_DATA   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/mem_port_sequencer_ack_timeout.sv
// Saturating wait counter for a pending memory request.
// Expires on the TMO_MAX-th request cycle without an ack.
module ack_timeout #(
  parameter int TMO_MAX = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CW   = (TMO_MAX < 1) ? 1 : $clog2(TMO_MAX + 1);
  localparam int LIMI = (TMO_MAX > 0) ? TMO_MAX - 1 : 0;
  localparam logic [CW-1:0] LIM  = CW'(LIMI);
  localparam logic [CW-1:0] MAXV = CW'(TMO_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && cnt_q < MAXV) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Fires in the cycle that would bring the count to TMO_MAX.
  assign expired = (TMO_MAX > 0) && run && (cnt_q >= LIM);

endmodule

// File: rtl/mem_port_sequencer.sv
// Shares one memory port between instruction fetch and data access.
// Each instruction runs FETCH -> DECODE -> [DATA] -> COMMIT.
module mem_port_sequencer
  import mem_port_sequencer_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TMO_MAX = TMO_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  output logic [DW-1:0] instr,
  input  logic          memwrite,
  input  logic          memread,
  input  logic [AW-1:0] aluout,
  input  logic [DW-1:0] writedata,
  output logic [DW-1:0] readdata,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          tmo_err
);

  state_e        state_q, state_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          tmo_q, tmo_d;
  logic          expired;
  logic          t_run, t_clear;

  assign t_run   = req_q & ~mem_ack;
  assign t_clear = mem_ack | (state_d != state_q);

  ack_timeout #(
    .TMO_MAX (TMO_MAX)
  ) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .run     (t_run),
    .clear   (t_clear),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    rdata_d = rdata_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      ST_FETCH: begin
        if (!req_q) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = pc;
        end else if (mem_ack) begin
          instr_d = mem_rdata;
          req_d   = 1'b0;
          state_d = ST_DECODE;
        end else if (expired) begin
          tmo_d   = 1'b1;
          req_d   = 1'b0;
          state_d = ST_COMMIT;
        end
      end
      ST_DECODE: begin
        if (memread | memwrite) begin
          addr_d  = aluout;
          wdata_d = writedata;
          we_d    = memwrite;
          state_d = ST_DATA;
        end else begin
          state_d = ST_COMMIT;
        end
      end
      ST_DATA: begin
        // Fields were captured in DECODE; core inputs are not looked at here.
        if (!req_q) begin
          req_d = 1'b1;
        end else if (mem_ack) begin
          if (!we_q) rdata_d = mem_rdata;
          req_d   = 1'b0;
          state_d = ST_COMMIT;
        end else if (expired) begin
          tmo_d   = 1'b1;
          req_d   = 1'b0;
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      instr_q <= '0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tmo_q   <= tmo_d;
    end
  end

  assign instr     = instr_q;
  assign readdata  = rdata_q;
  assign stall     = (state_q != ST_COMMIT);
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign tmo_err   = tmo_q;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer.
// Inputs are driven and outputs sampled on the falling edge.
module tb_mem_port_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic [31:0] instr;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic [31:0] aluout = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        tmo_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_sequencer #(
    .AW      (32),
    .DW      (32),
    .TMO_MAX (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .instr     (instr),
    .memwrite  (memwrite),
    .memread   (memread),
    .aluout    (aluout),
    .writedata (writedata),
    .readdata  (readdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .tmo_err   (tmo_err)
  );

  // Leaves reset released on a falling edge; FSM is in FETCH, no request.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ack = 1'b0;
    memread = 1'b0;
    memwrite = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_stall: got %h want 1", stall); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %h want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %h want 0", mem_we); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", instr); end
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", readdata); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
    checks++; if (tmo_err !== 1'b0) begin errors++; $display("FAIL rst_tmo: got %h want 0", tmo_err); end
  endtask

  task automatic test_alu();
    int lows;
    int low_at;
    int dreq;
    pc = 32'h0;
    do_reset();
    lows = 0; low_at = -1; dreq = 0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL alu_fetch: got req=%h addr=%h we=%h want 1/0/0", mem_req, mem_addr, mem_we);
    end
    mem_ack = 1'b1; mem_rdata = 32'h00221820;
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (stall === 1'b0) begin lows++; low_at = i; end
      if (mem_req === 1'b1) dreq++;
    end
    checks++; if (instr !== 32'h00221820) begin errors++; $display("FAIL alu_instr: got %h want 00221820", instr); end
    checks++; if (lows !== 1 || low_at !== 3) begin
      errors++; $display("FAIL alu_commit: got %0d lows at %0d want 1 at 3", lows, low_at);
    end
    checks++; if (dreq !== 0) begin errors++; $display("FAIL alu_nodata: got %0d req cycles want 0", dreq); end
  endtask

  task automatic test_load();
    pc = 32'h4;
    do_reset();
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h8C220040;
    @(negedge clk);
    mem_ack = 1'b0; memread = 1'b1; aluout = 32'h40;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
      errors++; $display("FAIL ld_req: got req=%h addr=%h we=%h want 1/40/0", mem_req, mem_addr, mem_we);
    end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ld_stall: got %h want 1", stall); end
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_ack = 1'b0; memread = 1'b0;
    checks++; if (readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_rdata: got %h want deadbeef", readdata); end
    checks++; if (stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL ld_commit: got stall=%h req=%h want 0/0", stall, mem_req);
    end
    checks++; if (instr !== 32'h8C220040) begin errors++; $display("FAIL ld_instr: got %h want 8c220040", instr); end
  endtask

  task automatic test_store();
    pc = 32'h8;
    do_reset();
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hAC220080;
    @(negedge clk);
    mem_ack = 1'b0; memwrite = 1'b1; aluout = 32'h80; writedata = 32'h12345678;
    @(negedge clk);
    aluout = 32'hFFF0; writedata = 32'h0; memwrite = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== 32'h12345678) begin
        errors++;
        $display("FAIL st_hold%0d: got req=%h we=%h addr=%h wd=%h want 1/1/80/12345678", i, mem_req, mem_we, mem_addr, mem_wdata);
      end
    end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin
      errors++; $display("FAIL st_ackcyc: got req=%h addr=%h want 1/80", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL st_commit: got stall=%h req=%h want 0/0", stall, mem_req);
    end
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL st_rdata: got %h want 0", readdata); end
    checks++; if (tmo_err !== 1'b0) begin errors++; $display("FAIL st_tmo: got %h want 0", tmo_err); end
  endtask

  task automatic test_timeout();
    int reqs;
    int n;
    pc = 32'hC;
    do_reset();
    reqs = 0; n = 0;
    @(negedge clk);
    while (tmo_err !== 1'b1 && n < 20) begin
      if (mem_req === 1'b1) reqs++;
      n++;
      @(negedge clk);
    end
    checks++; if (tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_set: got %h want 1", tmo_err); end
    checks++; if (reqs !== 8) begin errors++; $display("FAIL tmo_cycles: got %0d want 8", reqs); end
    checks++; if (stall !== 1'b0 || mem_req !== 1'b0 || instr !== 32'h0) begin
      errors++; $display("FAIL tmo_commit: got stall=%h req=%h instr=%h want 0/0/0", stall, mem_req, instr);
    end
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hC || stall !== 1'b1) begin
      errors++; $display("FAIL tmo_retry: got req=%h addr=%h stall=%h want 1/c/1", mem_req, mem_addr, stall);
    end
    checks++; if (tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %h want 1", tmo_err); end
  endtask

  task automatic test_spurious();
    pc = 32'h10;
    do_reset();
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h00000020;
    @(negedge clk);
    mem_rdata = 32'hBADBAD00;
    @(negedge clk);
    checks++; if (stall !== 1'b0 || mem_req !== 1'b0 || instr !== 32'h20) begin
      errors++; $display("FAIL sp_decode: got stall=%h req=%h instr=%h want 0/0/20", stall, mem_req, instr);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (stall !== 1'b1 || mem_req !== 1'b0 || instr !== 32'h20 || readdata !== 32'h0) begin
      errors++;
      $display("FAIL sp_commit: got stall=%h req=%h instr=%h rd=%h want 1/0/20/0", stall, mem_req, instr, readdata);
    end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
      errors++; $display("FAIL sp_fetch: got req=%h addr=%h want 1/10", mem_req, mem_addr);
    end
  endtask

  task automatic test_reset_mid();
    pc = 32'h20;
    do_reset();
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h8C230044;
    @(negedge clk);
    mem_ack = 1'b0; memread = 1'b1; aluout = 32'h44;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin
      errors++; $display("FAIL rm_data: got req=%h addr=%h want 1/44", mem_req, mem_addr);
    end
    #2;
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; pc = 32'h24;
    #1;
    checks++; if (mem_req !== 1'b0 || stall !== 1'b1 || instr !== 32'h0) begin
      errors++; $display("FAIL rm_async: got req=%h stall=%h instr=%h want 0/1/0", mem_req, stall, instr);
    end
    @(negedge clk);
    reset = 1'b0; memread = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h24 || mem_we !== 1'b0 || instr !== 32'h0) begin
      errors++;
      $display("FAIL rm_refetch: got req=%h addr=%h we=%h instr=%h want 1/24/0/0", mem_req, mem_addr, mem_we, instr);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_spurious();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
